// File: rtl/ctrl_script_player.sv
// ctrl_script_player
//   Scripted joypad stimulus sequencer. It plays a table of {frame delay, button mask}
//   entries and counts frames on vblank rising edges. A button update is held back while
//   the CPU is part-way through a controller read, so a read sequence never sees a torn mask.
//
// Ports
//   clk_cpu      CPU clock, all logic on the rising edge
//   rst_cpu_n    asynchronous active-low reset
//   script_we    table write strobe, honoured only when not playing (IDLE/DONE)
//   script_addr  table write index
//   script_data  {delay[FRAME_W-1:0], btns[7:0]}; delay == 0 terminates the script
//   start        begin playback from entry 0 (ignored while busy)
//   stop         abort to IDLE and clear btns; wins over start
//   vblank       PPU vblank level; each rising edge is one frame
//   strobe       controller strobe
//   rd           controller read pulse
//   btns         button mask driven to the controller model
//   busy         playback in progress (LOAD/WAIT/APPLY)
//   done         script finished (DONE)
//   entry_idx    entry currently loaded/pending; in DONE, the last applied entry
//   frame_count  frames seen since start, wraps
module ctrl_script_player #(
   parameter int unsigned  DEPTH   = 64,
   parameter int unsigned  FRAME_W = 16,
   localparam int unsigned AW      = $clog2(DEPTH)
) (
   input  logic               clk_cpu,
   input  logic               rst_cpu_n,
   input  logic               script_we,
   input  logic [AW-1:0]      script_addr,
   input  logic [FRAME_W+7:0] script_data,
   input  logic               start,
   input  logic               stop,
   input  logic               vblank,
   input  logic               strobe,
   input  logic               rd,
   output logic [7:0]         btns,
   output logic               busy,
   output logic               done,
   output logic [AW-1:0]      entry_idx,
   output logic [FRAME_W-1:0] frame_count
);

   typedef enum logic [2:0] {StIdle, StLoad, StWait, StApply, StDone} state_e;

   state_e               state_q, state_d;
   logic [7:0]           btns_q, btns_d;
   logic [7:0]           pend_q, pend_d;
   logic [AW-1:0]        idx_q, idx_d;
   logic [FRAME_W-1:0]   fc_q, fc_d;
   logic [FRAME_W-1:0]   cnt_q, cnt_d;
   logic                 vblank_q, rd_q;
   logic [3:0]           rd_cnt_q, rd_cnt_d;

   logic [FRAME_W+7:0]   mem [DEPTH];
   logic [FRAME_W+7:0]   rdata_q;

   logic                 vb_edge, rd_edge, pad_busy, idle_like;
   logic [FRAME_W-1:0]   ent_delay;
   logic [7:0]           ent_btns;

   assign vb_edge   = vblank & ~vblank_q;
   assign rd_edge   = rd & ~rd_q;
   // A read burst is in flight from the first read after strobe drops until the 8th read.
   assign pad_busy  = strobe | ((rd_cnt_q != 4'd0) & (rd_cnt_q != 4'd8));
   assign idle_like = (state_q == StIdle) | (state_q == StDone);
   assign ent_delay = rdata_q[FRAME_W+7:8];
   assign ent_btns  = rdata_q[7:0];

   // Script table: no reset; the read address is the next-cycle index, so data for the
   // entry being entered is present during LOAD.
   always_ff @(posedge clk_cpu) begin
      if (script_we && idle_like) begin
         mem[script_addr] <= script_data;
      end
      rdata_q <= mem[idx_d];
   end

   always_comb begin
      rd_cnt_d = rd_cnt_q;
      if (strobe) begin
         rd_cnt_d = 4'd0;
      end else if (rd_edge && (rd_cnt_q != 4'd8)) begin
         rd_cnt_d = rd_cnt_q + 4'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      btns_d  = btns_q;
      pend_d  = pend_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      fc_d    = fc_q;

      if (vb_edge && !idle_like) begin
         fc_d = fc_q + FRAME_W'(1);
      end

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StLoad;
               idx_d   = '0;
               fc_d    = '0;
            end
         end
         StLoad: begin
            if (ent_delay == '0) begin
               // Terminator: report the last entry that was actually applied.
               state_d = StDone;
               if (idx_q != '0) begin
                  idx_d = idx_q - AW'(1);
               end
            end else begin
               cnt_d   = ent_delay;
               pend_d  = ent_btns;
               state_d = StWait;
            end
         end
         StWait: begin
            if (vb_edge) begin
               cnt_d = cnt_q - FRAME_W'(1);
               if (cnt_q == FRAME_W'(1)) begin
                  state_d = StApply;
               end
            end
         end
         StApply: begin
            if (!pad_busy) begin
               btns_d = pend_q;
               if (idx_q == AW'(DEPTH - 1)) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = StLoad;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (stop) begin
         state_d = StIdle;
         btns_d  = '0;
         idx_d   = '0;
      end
   end

   always_ff @(posedge clk_cpu or negedge rst_cpu_n) begin
      if (!rst_cpu_n) begin
         state_q  <= StIdle;
         btns_q   <= '0;
         pend_q   <= '0;
         idx_q    <= '0;
         fc_q     <= '0;
         cnt_q    <= '0;
         vblank_q <= 1'b0;
         rd_q     <= 1'b0;
         rd_cnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         btns_q   <= btns_d;
         pend_q   <= pend_d;
         idx_q    <= idx_d;
         fc_q     <= fc_d;
         cnt_q    <= cnt_d;
         vblank_q <= vblank;
         rd_q     <= rd;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign btns        = btns_q;
   assign busy        = (state_q == StLoad) | (state_q == StWait) | (state_q == StApply);
   assign done        = (state_q == StDone);
   assign entry_idx   = idx_q;
   assign frame_count = fc_q;

endmodule
